// File: rtl/eq_band_mixer_ctrl_pkg.sv
// Shared constants, FSM encodings and rounding helper for the band gain/mix scheduler.
package eq_band_mixer_ctrl_pkg;

  localparam int NUM_BANDS  = 10;
  localparam int SAMPLE_W   = 24;
  localparam int GAIN_W     = 16;
  localparam int GAIN_FRAC  = 14;
  localparam int PROD_W     = SAMPLE_W + GAIN_W;
  localparam int ACC_W      = 44;
  localparam int IDX_W      = 4;
  localparam int GAIN_UNITY = 16384;
  localparam int SAMPLE_MAX = 8388607;
  localparam int SAMPLE_MIN = -8388608;

  localparam logic [IDX_W-1:0] BAND_LAST = IDX_W'(NUM_BANDS - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_MAC   = 2'd1;
  localparam logic [1:0] ST_ROUND = 2'd2;

  // Round-half-up back to sample scale; the arithmetic shift floors negative values.
  function automatic logic signed [ACC_W-1:0] round_q14(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] biased;
    biased = acc + ACC_W'(1 << (GAIN_FRAC - 1));
    return biased >>> GAIN_FRAC;
  endfunction

endpackage

// File: rtl/eq_band_mixer_ctrl_gain_regfile.sv
// Per-band gain storage: host writes land in a shadow bank, which is copied to the
// active bank only when a new sample is accepted.
module eq_gain_regfile
  import eq_band_mixer_ctrl_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_wr_en,
  input  logic [IDX_W-1:0]         i_wr_addr,
  input  logic signed [GAIN_W-1:0] i_wr_data,
  input  logic                     i_commit,
  input  logic [IDX_W-1:0]         i_rd_idx,
  output logic signed [GAIN_W-1:0] o_rd_gain
);

  logic signed [GAIN_W-1:0] r_shadow [NUM_BANDS];
  logic signed [GAIN_W-1:0] r_active [NUM_BANDS];

  // Commit samples the shadow bank before a same-cycle write lands in it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_BANDS; k++) begin
        r_shadow[k] <= GAIN_W'(GAIN_UNITY);
        r_active[k] <= GAIN_W'(GAIN_UNITY);
      end
    end else begin
      if (i_wr_en && (i_wr_addr <= BAND_LAST)) begin
        r_shadow[i_wr_addr] <= i_wr_data;
      end
      if (i_commit) begin
        r_active <= r_shadow;
      end
    end
  end

  assign o_rd_gain = r_active[i_rd_idx];

endmodule

// File: rtl/eq_band_mixer_ctrl.sv
// Gain-and-mix scheduler: snapshots ten band samples, MACs them through one shared
// 24x16 multiplier, then rounds and saturates to a single 24-bit output sample.
module eq_band_mixer_ctrl
  import eq_band_mixer_ctrl_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          enable,
  input  logic                          sample_valid,
  input  logic [NUM_BANDS*SAMPLE_W-1:0] band_bus,
  input  logic                          gain_wr_en,
  input  logic [IDX_W-1:0]              gain_wr_addr,
  input  logic [GAIN_W-1:0]             gain_wr_data,
  input  logic                          overrun_clr,
  output logic [SAMPLE_W-1:0]           audio_out,
  output logic                          out_valid,
  output logic                          clip,
  output logic                          busy,
  output logic                          overrun
);

  logic [1:0]                 r_state;
  logic [IDX_W-1:0]           r_idx;
  logic signed [SAMPLE_W-1:0] r_snap [NUM_BANDS];
  logic signed [ACC_W-1:0]    r_acc;
  logic signed [SAMPLE_W-1:0] r_audio;
  logic                       r_valid;
  logic                       r_clip;
  logic                       r_overrun;

  logic                       w_accept;
  logic                       w_busy;
  logic signed [GAIN_W-1:0]   w_gain;
  logic signed [PROD_W-1:0]   w_prod;
  logic signed [ACC_W-1:0]    w_rounded;
  logic signed [SAMPLE_W-1:0] w_sat;
  logic                       w_clip;

  assign w_busy   = (r_state == ST_MAC) || (r_state == ST_ROUND);
  assign w_accept = enable && sample_valid && (r_state == ST_IDLE);

  eq_gain_regfile u_gains (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_wr_en   (gain_wr_en),
    .i_wr_addr (gain_wr_addr),
    .i_wr_data (gain_wr_data),
    .i_commit  (w_accept),
    .i_rd_idx  (r_idx),
    .o_rd_gain (w_gain)
  );

  assign w_prod = PROD_W'(r_snap[r_idx]) * PROD_W'(w_gain);

  always_comb begin
    w_rounded = round_q14(r_acc);
    w_clip    = 1'b0;
    w_sat     = w_rounded[SAMPLE_W-1:0];
    if (w_rounded > ACC_W'(SAMPLE_MAX)) begin
      w_sat  = SAMPLE_W'(SAMPLE_MAX);
      w_clip = 1'b1;
    end else if (w_rounded < ACC_W'(SAMPLE_MIN)) begin
      w_sat  = SAMPLE_W'(SAMPLE_MIN);
      w_clip = 1'b1;
    end
  end

  // Overrun only counts samples that arrive while enabled; a new set beats a clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overrun <= 1'b0;
    end else if (enable && sample_valid && w_busy) begin
      r_overrun <= 1'b1;
    end else if (overrun_clr) begin
      r_overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_acc   <= '0;
      r_audio <= '0;
      r_valid <= 1'b0;
      r_clip  <= 1'b0;
      for (int k = 0; k < NUM_BANDS; k++) begin
        r_snap[k] <= '0;
      end
    end else begin
      r_valid <= 1'b0;
      r_clip  <= 1'b0;
      if (enable) begin
        case (r_state)
          ST_IDLE: begin
            if (sample_valid) begin
              for (int k = 0; k < NUM_BANDS; k++) begin
                r_snap[k] <= band_bus[k*SAMPLE_W +: SAMPLE_W];
              end
              r_acc   <= '0;
              r_idx   <= '0;
              r_state <= ST_MAC;
            end
          end
          ST_MAC: begin
            r_acc <= r_acc + ACC_W'(w_prod);
            if (r_idx == BAND_LAST) begin
              r_idx   <= '0;
              r_state <= ST_ROUND;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
          ST_ROUND: begin
            r_audio <= w_sat;
            r_clip  <= w_clip;
            r_valid <= 1'b1;
            r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign audio_out = r_audio;
  assign out_valid = r_valid;
  assign clip      = r_clip;
  assign busy      = w_busy;
  assign overrun   = r_overrun;

endmodule
